cmos_capture_ctrl: RTL and testbench



---
 rtl/cmos_capture_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_cmos_capture_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_ctrl.sv
// cmos_capture_ctrl: sequences the CMOS pixel stream into the frame buffer.
// Waits for sensor init, drops warm-up frames, arms on request at a frame
// boundary, crops a fixed window into sequential buffer writes and flags
// frames whose line/row geometry does not match the expected sensor timing.
module cmos_capture_ctrl #(
  parameter int H_ACT       = 320,
  parameter int V_ACT       = 240,
  parameter int X0          = 0,
  parameter int Y0          = 0,
  parameter int WIN_W       = 320,
  parameter int WIN_H       = 240,
  parameter int SKIP_FRAMES = 10,
  parameter int ADDR_W      = 17
) (
  input  logic              CMOS_PCLK,
  input  logic              iRST_N,
  input  logic              Init_Done,
  input  logic              CMOS_VSYNC,
  input  logic              CMOS_HREF,
  input  logic              iPIX_EN,
  input  logic [7:0]        iPIX_DATA,
  input  logic              cap_start,
  input  logic              cap_mode,
  input  logic              cap_stop,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy,
  output logic              ready
);

  // Geometry constants folded to the 16-bit counter width.
  localparam logic [15:0] H_ACT_C = 16'(H_ACT);
  localparam logic [15:0] V_ACT_C = 16'(V_ACT);
  localparam logic [15:0] X_LO    = 16'(X0);
  localparam logic [15:0] Y_LO    = 16'(Y0);
  localparam logic [15:0] W_C     = 16'(WIN_W);
  localparam logic [15:0] H_C     = 16'(WIN_H);
  localparam logic [15:0] SKIP_C  = 16'(SKIP_FRAMES);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  // Write index carries one extra bit: MSB set means the buffer is full.
  localparam int          IDX_W   = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_WARMUP,
    S_READY,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                vsync_q, href_q;
  logic [15:0]         col_q, col_d;
  logic [15:0]         row_q, row_d;
  logic [15:0]         skip_q, skip_d;
  logic                mode_q, mode_d;
  logic                stop_q, stop_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  logic                fs, fe, le, pix, in_win;
  logic [15:0]         col_off, row_off;

  // Sync edge events and the crop-window test for the current pixel.
  always_comb begin
    fs  = vsync_q & ~CMOS_VSYNC;
    fe  = ~vsync_q & CMOS_VSYNC;
    le  = href_q & ~CMOS_HREF;
    pix = iPIX_EN & CMOS_HREF;
    // Offsets wrap to huge values when below the window origin, so a single
    // unsigned compare covers both the lower and upper window bound.
    col_off = col_q - X_LO;
    row_off = row_q - Y_LO;
    in_win  = pix & ~CMOS_VSYNC & (col_off < W_C) & (row_off < H_C);
  end

  // Column/row position within the incoming frame, saturating at full scale.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (fs) begin
      col_d = '0;
      row_d = '0;
    end else if (le) begin
      col_d = '0;
      if (row_q != CNT_MAX) row_d = row_q + 16'd1;
    end else if (pix && (col_q != CNT_MAX)) begin
      col_d = col_q + 16'd1;
    end
  end

  // Capture state machine: next state, buffer writes, error tracking, outputs.
  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    mode_d       = mode_q;
    stop_d       = stop_q;
    err_d        = err_q;
    idx_d        = idx_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (((state_q == S_ARMED) || (state_q == S_CAPTURE) || (state_q == S_DONE)) && cap_stop)
      stop_d = 1'b1;

    case (state_q)
      S_WAIT_INIT: begin
        skip_d = '0;
        stop_d = 1'b0;
        if (Init_Done) state_d = S_WARMUP;
      end

      S_WARMUP: begin
        if (fe) skip_d = skip_q + 16'd1;
        if (skip_d >= SKIP_C) state_d = S_READY;
      end

      S_READY: begin
        if (cap_start) begin
          mode_d  = cap_mode;
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (cap_stop) begin
          state_d = S_READY;
        end else if (fs) begin
          idx_d     = '0;
          wr_addr_d = '0;
          err_d     = 1'b0;
          state_d   = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (in_win) begin
          if (!idx_q[ADDR_W]) begin
            wr_en_d   = 1'b1;
            wr_data_d = iPIX_DATA;
            wr_addr_d = idx_q[ADDR_W-1:0];
            idx_d     = idx_q + IDX_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        if (le && (col_q != H_ACT_C)) err_d = 1'b1;
        if (pix && (col_q >= H_ACT_C)) err_d = 1'b1;
        if (fe) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
          frame_err_d  = err_d | (row_d != V_ACT_C);
        end
      end

      S_DONE: begin
        if (mode_q && !stop_q && !cap_stop) state_d = S_ARMED;
        else                                state_d = S_READY;
      end

      default: state_d = S_WAIT_INIT;
    endcase

    if (state_d == S_READY) stop_d = 1'b0;

    // Losing sensor init aborts whatever is in progress without a frame report.
    if (!Init_Done) begin
      state_d      = S_WAIT_INIT;
      wr_en_d      = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      skip_d       = '0;
      stop_d       = 1'b0;
    end

    busy_d  = (state_d == S_ARMED) || (state_d == S_CAPTURE) || (state_d == S_DONE);
    ready_d = (state_d == S_READY);
  end

  // State, counters and registered outputs; reset drops any frame in flight.
  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_WAIT_INIT;
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      skip_q       <= '0;
      mode_q       <= 1'b0;
      stop_q       <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= CMOS_VSYNC;
      href_q       <= CMOS_HREF;
      col_q        <= col_d;
      row_q        <= row_d;
      skip_q       <= skip_d;
      mode_q       <= mode_d;
      stop_q       <= stop_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// tb_cmos_capture_ctrl: drives synthetic 8x4 frames into two instances, one
// with a 4x2 crop window and a buffer exactly the crop size, one capturing the
// full frame into a 32-entry buffer, and checks writes, frame reports and state.
module tb_cmos_capture_ctrl;

  localparam int H_ACT = 8;
  localparam int V_ACT = 4;

  logic       CMOS_PCLK;
  logic       iRST_N;
  logic       Init_Done;
  logic       CMOS_VSYNC;
  logic       CMOS_HREF;
  logic       iPIX_EN;
  logic [7:0] iPIX_DATA;
  logic       cap_start;
  logic       cap_mode;
  logic       cap_stop;

  logic       wr_en, frame_done, frame_err, busy, ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       f_wr_en, f_frame_done, f_frame_err, f_busy, f_ready;
  logic [4:0] f_wr_addr;
  logic [7:0] f_wr_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic        done_err[$];
  logic [31:0] fq_addr[$];
  logic        f_done_err[$];
  int          stray_err = 0;

  logic pre_ready, fe_ready, fe_done, fe_err;

  cmos_capture_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .X0(2), .Y0(1), .WIN_W(4), .WIN_H(2),
    .SKIP_FRAMES(2), .ADDR_W(3)
  ) dut (
    .CMOS_PCLK(CMOS_PCLK), .iRST_N(iRST_N), .Init_Done(Init_Done),
    .CMOS_VSYNC(CMOS_VSYNC), .CMOS_HREF(CMOS_HREF), .iPIX_EN(iPIX_EN),
    .iPIX_DATA(iPIX_DATA), .cap_start(cap_start), .cap_mode(cap_mode),
    .cap_stop(cap_stop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy), .ready(ready)
  );

  cmos_capture_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .X0(0), .Y0(0), .WIN_W(8), .WIN_H(4),
    .SKIP_FRAMES(2), .ADDR_W(5)
  ) dut_full (
    .CMOS_PCLK(CMOS_PCLK), .iRST_N(iRST_N), .Init_Done(Init_Done),
    .CMOS_VSYNC(CMOS_VSYNC), .CMOS_HREF(CMOS_HREF), .iPIX_EN(iPIX_EN),
    .iPIX_DATA(iPIX_DATA), .cap_start(cap_start), .cap_mode(cap_mode),
    .cap_stop(cap_stop), .wr_en(f_wr_en), .wr_addr(f_wr_addr), .wr_data(f_wr_data),
    .frame_done(f_frame_done), .frame_err(f_frame_err), .busy(f_busy), .ready(f_ready)
  );

  initial CMOS_PCLK = 1'b0;
  always #5 CMOS_PCLK = ~CMOS_PCLK;

  // Record every buffer write and frame report as seen between clock edges.
  always @(negedge CMOS_PCLK) begin
    if (wr_en) begin
      wq_addr.push_back(32'(wr_addr));
      wq_data.push_back(32'(wr_data));
    end
    if (frame_done) done_err.push_back(frame_err);
    if (frame_err && !frame_done) stray_err++;
    if (f_wr_en) fq_addr.push_back(32'(f_wr_addr));
    if (f_frame_done) f_done_err.push_back(f_frame_err);
    if (f_frame_err && !f_frame_done) stray_err++;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no finish, expected finish within 1 ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(negedge CMOS_PCLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: idle VSYNC high, FS, n_rows lines of pixels (data row*8+col),
  // FE, then idle. Optional start/stop pulses before a given line, a stop
  // coincident with FE (stop_line == -2), and an Init_Done drop mid-line.
  task automatic send_frame(input int n_rows, input int odd_line, input int odd_len,
                            input int stop_line, input int start_line,
                            input logic start_mode, input int drop_line);
    CMOS_VSYNC = 1'b1;
    repeat (2) tick();
    CMOS_VSYNC = 1'b0;
    repeat (2) tick();
    for (int r = 0; r < n_rows; r++) begin
      int len;
      len = (r == odd_line) ? odd_len : H_ACT;
      if (r == stop_line) cap_stop = 1'b1;
      if (r == start_line) begin
        cap_start = 1'b1;
        cap_mode  = start_mode;
      end
      tick();
      cap_stop  = 1'b0;
      cap_start = 1'b0;
      CMOS_HREF = 1'b1;
      for (int c = 0; c < len; c++) begin
        iPIX_EN   = 1'b1;
        iPIX_DATA = 8'(r * 8 + c);
        if (r == drop_line && c == 3) Init_Done = 1'b0;
        tick();
        if (r == drop_line && c == 3) begin
          check("drop_wr_en", 32'(wr_en), 0);
          check("drop_full_wr_en", 32'(f_wr_en), 0);
        end
      end
      iPIX_EN   = 1'b0;
      CMOS_HREF = 1'b0;
      repeat (2) tick();
    end
    pre_ready = ready;
    if (stop_line == -2) cap_stop = 1'b1;
    CMOS_VSYNC = 1'b1;
    tick();
    cap_stop = 1'b0;
    fe_ready = ready;
    fe_done  = frame_done;
    fe_err   = frame_err;
    repeat (3) tick();
  endtask

  task automatic pulse_start(input logic mode);
    cap_start = 1'b1;
    cap_mode  = mode;
    tick();
    cap_start = 1'b0;
  endtask

  typedef struct {
    int do_start;
    int mode;
    int n_frames;
    int stop_frame;
    int stop_line;
    int odd_line;
    int odd_len;
    int n_rows;
    int exp_wr;
    int exp_fwr;
    int exp_done;
    int exp_mask;
    int exp_fmask;
    int chk_data;
  } vec_t;

  vec_t tbl[7];
  int   exp_data[8];

  initial begin : main
    int base_w, base_f, base_d, base_fd;
    logic [31:0] m, fm;

    // do_start mode frames stop_frame stop_line odd_line odd_len rows |
    // crop_writes full_writes dones crop_err_mask full_err_mask chk_data
    tbl[0] = '{1, 0, 1, -1, -1, -1, 8, 4,  8, 32, 1, 0, 0, 1}; // single crop
    tbl[1] = '{1, 1, 3,  1,  2, -1, 8, 4, 16, 64, 2, 0, 0, 0}; // continuous, stop in frame 2
    tbl[2] = '{1, 1, 2,  1,  2,  1, 7, 4, 16, 63, 2, 1, 1, 0}; // short line then clean frame
    tbl[3] = '{1, 0, 1, -1, -1,  2, 9, 4,  8, 32, 1, 1, 1, 0}; // long line, full buffer saturates
    tbl[4] = '{1, 0, 1, -1, -1, -1, 8, 5,  8, 32, 1, 1, 1, 0}; // extra row
    tbl[5] = '{1, 1, 2,  0, -2, -1, 8, 4,  8, 32, 1, 0, 0, 0}; // stop coincident with FE
    tbl[6] = '{0, 0, 1, -1, -1, -1, 8, 4,  0,  0, 0, 0, 0, 0}; // no request
    exp_data = '{10, 11, 12, 13, 18, 19, 20, 21};

    iRST_N     = 1'b0;
    Init_Done  = 1'b1;
    CMOS_VSYNC = 1'b1;
    CMOS_HREF  = 1'b0;
    iPIX_EN    = 1'b0;
    iPIX_DATA  = 8'd0;
    cap_start  = 1'b0;
    cap_mode   = 1'b0;
    cap_stop   = 1'b0;
    repeat (3) tick();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    iRST_N = 1'b1;
    repeat (2) tick();

    // Warm-up: ready only after the second FE, never any writes.
    send_frame(4, -1, 8, -1, -1, 1'b0, -1);
    check("warmup1_ready", 32'(fe_ready), 0);
    send_frame(4, -1, 8, -1, -1, 1'b0, -1);
    check("warmup2_pre_ready", 32'(pre_ready), 0);
    check("warmup2_ready", 32'(fe_ready), 1);
    send_frame(4, -1, 8, -1, -1, 1'b0, -1);
    check("idle_writes", 32'(wq_addr.size()), 0);
    check("idle_full_writes", 32'(fq_addr.size()), 0);
    check("idle_dones", 32'(done_err.size()), 0);
    check("idle_ready", 32'(ready), 1);

    // Frame-level scenarios from the table.
    for (int t = 0; t < 7; t++) begin
      base_w  = wq_addr.size();
      base_f  = fq_addr.size();
      base_d  = done_err.size();
      base_fd = f_done_err.size();
      if (tbl[t].do_start != 0) pulse_start(tbl[t].mode != 0);
      for (int f = 0; f < tbl[t].n_frames; f++) begin
        send_frame(tbl[t].n_rows,
                   (f == 0) ? tbl[t].odd_line : -1, tbl[t].odd_len,
                   (f == tbl[t].stop_frame) ? tbl[t].stop_line : -1,
                   -1, 1'b0, -1);
      end
      m  = '0;
      fm = '0;
      for (int i = base_d; i < done_err.size(); i++) m = m | (32'(done_err[i]) << (i - base_d));
      for (int i = base_fd; i < f_done_err.size(); i++) fm = fm | (32'(f_done_err[i]) << (i - base_fd));
      $display("[TB] vector %0d", t);
      check("vec_crop_writes", 32'(wq_addr.size() - base_w), 32'(tbl[t].exp_wr));
      check("vec_full_writes", 32'(fq_addr.size() - base_f), 32'(tbl[t].exp_fwr));
      check("vec_dones", 32'(done_err.size() - base_d), 32'(tbl[t].exp_done));
      check("vec_full_dones", 32'(f_done_err.size() - base_fd), 32'(tbl[t].exp_done));
      check("vec_err_mask", m, 32'(tbl[t].exp_mask));
      check("vec_full_err_mask", fm, 32'(tbl[t].exp_fmask));
      check("vec_ready", 32'(ready), 1);
      if (tbl[t].n_frames == 1 && tbl[t].exp_done == 1) begin
        check("vec_fe_done", 32'(fe_done), 1);
        check("vec_fe_err", 32'(fe_err), 32'(tbl[t].exp_mask));
      end
      if (tbl[t].exp_done >= 2) begin
        if (wq_addr.size() > base_w + tbl[t].exp_wr - 8)
          check("vec_crop_restart", wq_addr[base_w + tbl[t].exp_wr - 8], 0);
        else
          check("vec_crop_restart_missing", 32'(wq_addr.size()), 32'(base_w + tbl[t].exp_wr));
        if (fq_addr.size() > base_f + tbl[t].exp_fwr - 32)
          check("vec_full_restart", fq_addr[base_f + tbl[t].exp_fwr - 32], 0);
        else
          check("vec_full_restart_missing", 32'(fq_addr.size()), 32'(base_f + tbl[t].exp_fwr));
      end
      if (tbl[t].chk_data != 0) begin
        for (int i = 0; i < 8; i++) begin
          if (base_w + i < wq_addr.size()) begin
            check("crop_addr", wq_addr[base_w + i], 32'(i));
            check("crop_data", wq_data[base_w + i], 32'(exp_data[i]));
          end else begin
            check("crop_write_missing", 32'(wq_addr.size()), 32'(base_w + 8));
          end
        end
      end
    end

    // Request arriving mid-frame waits for the next frame start.
    base_w = wq_addr.size();
    base_d = done_err.size();
    send_frame(4, -1, 8, -1, 1, 1'b0, -1);
    check("midarm_writes", 32'(wq_addr.size() - base_w), 0);
    check("midarm_dones", 32'(done_err.size() - base_d), 0);
    check("midarm_busy", 32'(busy), 1);
    // A continuous-mode request during capture must be ignored.
    send_frame(4, -1, 8, -1, 2, 1'b1, -1);
    check("midarm_next_writes", 32'(wq_addr.size() - base_w), 8);
    check("midarm_next_done", 32'(fe_done), 1);
    check("ignored_start_ready", 32'(ready), 1);
    send_frame(4, -1, 8, -1, -1, 1'b0, -1);
    check("ignored_start_writes", 32'(wq_addr.size() - base_w), 8);

    // Stop while armed returns to READY at once.
    pulse_start(1'b1);
    check("armed_busy", 32'(busy), 1);
    check("armed_ready", 32'(ready), 0);
    cap_stop = 1'b1;
    tick();
    cap_stop = 1'b0;
    check("armed_stop_ready", 32'(ready), 1);
    check("armed_stop_busy", 32'(busy), 0);

    // Init_Done lost during capture aborts the frame and re-runs warm-up.
    pulse_start(1'b0);
    base_d = done_err.size();
    send_frame(4, -1, 8, -1, -1, 1'b0, 1);
    check("drop_dones", 32'(done_err.size() - base_d), 0);
    check("drop_ready", 32'(ready), 0);
    check("drop_busy", 32'(busy), 0);
    Init_Done = 1'b1;
    tick();
    send_frame(4, -1, 8, -1, -1, 1'b0, -1);
    check("rewarm1_ready", 32'(fe_ready), 0);
    send_frame(4, -1, 8, -1, -1, 1'b0, -1);
    check("rewarm2_ready", 32'(fe_ready), 1);

    check("stray_frame_err", 32'(stray_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
